// File: rtl/popcount_mc.sv
// popcount_mc: tagged words queue in a shared FIFO, one serial engine counts
// CHUNK_BITS per cycle and commits into per-channel saturating accumulators.
// Ports: ACLK, ARESET (async, active-high); WRITE_DATA/CH/MODE/VALID/READY
// word input; COUNT_RST per-channel clear; COUNT_FLAT packed accumulators;
// COUNT_BUSY per-channel pending flag; SATURATED sticky clip flag.
module popcount_mc #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CHUNK_BITS  = 8,
  parameter int COUNT_WIDTH = 32,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [DATA_WIDTH-1:0]         WRITE_DATA,
  input  logic [CHW-1:0]                WRITE_CH,
  input  logic                          WRITE_MODE,
  input  logic                          WRITE_VALID,
  output logic                          WRITE_READY,
  input  logic [NUM_CH-1:0]             COUNT_RST,
  output logic [NUM_CH*COUNT_WIDTH-1:0] COUNT_FLAT,
  output logic [NUM_CH-1:0]             COUNT_BUSY,
  output logic [NUM_CH-1:0]             SATURATED
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + CHW + 1;
  localparam int PW = $clog2(DATA_WIDTH + 1);
  localparam int NW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int QW = $clog2(FIFO_DEPTH + 2);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;
  state_t state, nstate;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW:0] wptr, rptr, used, used_n;
  logic rdy, push, pop, empty, commit, last;

  logic [DATA_WIDTH-1:0] sh;
  logic [PW-1:0] part, chunk_cnt;
  logic [CHUNK_BITS-1:0] chunk;
  logic [NW-1:0] idx;
  logic [CHW-1:0] e_ch;
  logic e_mode;

  logic [COUNT_WIDTH-1:0] acc [NUM_CH];
  logic [COUNT_WIDTH:0] sum [NUM_CH];
  logic [QW-1:0] pend [NUM_CH];
  logic [NUM_CH-1:0] hit, inc, sat;

  assign used   = wptr - rptr;
  assign empty  = (used == '0);
  assign push   = WRITE_VALID && rdy;
  assign pop    = (state == IDLE) && !empty;
  assign used_n = used + (AW+1)'(push) - (AW+1)'(pop);
  assign head   = mem[rptr[AW-1:0]];
  assign commit = (state == COMMIT);
  assign last   = (idx == NW'(NCHUNK - 1));

  assign WRITE_READY = rdy;
  assign SATURATED   = sat;

  // Ready is registered from the post-edge fill level, so it is low in
  // reset and a full FIFO refuses a push even when a pop is in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wptr <= '0;
      rptr <= '0;
      rdy  <= 1'b0;
    end else begin
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(pop);
      rdy  <= (used_n != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wptr[AW-1:0]] <= {WRITE_DATA, WRITE_CH, WRITE_MODE};
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (!empty) nstate = COUNT;
      COUNT:   if (last) nstate = COMMIT;
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    chunk = sh[CHUNK_BITS-1:0] ^ {CHUNK_BITS{e_mode}};
    chunk_cnt = '0;
    for (int b = 0; b < CHUNK_BITS; b++)
      chunk_cnt = chunk_cnt + PW'(chunk[b]);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sh     <= '0;
      part   <= '0;
      idx    <= '0;
      e_ch   <= '0;
      e_mode <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pop) begin
          sh     <= head[EW-1 -: DATA_WIDTH];
          e_ch   <= head[CHW:1];
          e_mode <= head[0];
          part   <= '0;
          idx    <= '0;
        end
        COUNT: begin
          part <= part + chunk_cnt;
          sh   <= sh >> CHUNK_BITS;
          idx  <= idx + NW'(1);
        end
        default: ;
      endcase
    end
  end

  // Out-of-range channel tags match no channel: no update, no busy effect.
  always_comb begin
    hit = '0;
    inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = commit && (int'(e_ch) == i);
      inc[i] = push && (int'(WRITE_CH) == i);
      sum[i] = {1'b0, acc[i]} + (COUNT_WIDTH+1)'(part);
    end
  end

  // A clear beats a same-cycle commit; the pending count still drops.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sat <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]  <= '0;
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pend[i] <= pend[i] + QW'(inc[i]) - QW'(hit[i]);
        if (COUNT_RST[i]) begin
          acc[i] <= '0;
          sat[i] <= 1'b0;
        end else if (hit[i]) begin
          if (sum[i][COUNT_WIDTH]) begin
            acc[i] <= '1;
            sat[i] <= 1'b1;
          end else begin
            acc[i] <= sum[i][COUNT_WIDTH-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    COUNT_FLAT = '0;
    COUNT_BUSY = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      COUNT_FLAT[COUNT_WIDTH*i +: COUNT_WIDTH] = acc[i];
      COUNT_BUSY[i] = (pend[i] != '0);
    end
  end

endmodule

// File: tb/tb_popcount_mc.sv
// tb_popcount_mc: table vectors plus hand sequences, with a per-channel
// scoreboard of expected accumulator values checked on every change.
module tb_popcount_mc;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ch;
    logic        mode;
    int          exp;
  } vec_t;

  typedef logic [31:0] u32_q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [31:0] wdata;
  logic [1:0] wch;
  logic wmode, wvalid, wready;
  logic [3:0] crst, busy, sat;
  logic [127:0] flat;

  logic [31:0] s_wdata;
  logic [1:0] s_wch;
  logic s_wmode, s_wvalid, s_wready;
  logic [3:0] s_crst, s_busy, s_sat;
  logic [23:0] s_flat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mdl [4];
  logic [31:0] last_v [4];
  u32_q q [4];
  vec_t tbl [9];

  popcount_mc u_dut (
    .ACLK(clk), .ARESET(rst),
    .WRITE_DATA(wdata), .WRITE_CH(wch), .WRITE_MODE(wmode),
    .WRITE_VALID(wvalid), .WRITE_READY(wready),
    .COUNT_RST(crst), .COUNT_FLAT(flat),
    .COUNT_BUSY(busy), .SATURATED(sat)
  );

  popcount_mc #(.COUNT_WIDTH(6)) u_sat (
    .ACLK(clk), .ARESET(rst),
    .WRITE_DATA(s_wdata), .WRITE_CH(s_wch), .WRITE_MODE(s_wmode),
    .WRITE_VALID(s_wvalid), .WRITE_READY(s_wready),
    .COUNT_RST(s_crst), .COUNT_FLAT(s_flat),
    .COUNT_BUSY(s_busy), .SATURATED(s_sat)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] acc_of(input int c);
    return flat[32*c +: 32];
  endfunction

  task automatic expect_acc(input int c, input logic [31:0] v);
    if (v != mdl[c]) begin
      mdl[c] = v;
      q[c].push_back(v);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] cur;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cur = flat[32*i +: 32];
        if (cur !== last_v[i]) begin
          if (q[i].size() == 0)
            chk($sformatf("sb_unexpected_ch%0d", i), cur, last_v[i]);
          else
            chk($sformatf("sb_ch%0d", i), cur, q[i].pop_front());
          last_v[i] = cur;
        end
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic put(input logic [31:0] d, input logic [1:0] c,
                     input logic m, output int t);
    int k;
    wdata = d; wch = c; wmode = m; wvalid = 1'b1;
    k = 0;
    while (!wready && k < 100) begin
      @(negedge clk);
      k++;
    end
    t = cyc + 1;
    if (!wready) begin
      chk("put_timeout", 0, 1);
      t = -1;
    end else begin
      @(negedge clk);
    end
    wvalid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy !== 4'd0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 4'd0) chk("drain_timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_ready_low", wready, 0);
    chk("rst_flat_zero", flat, 0);
    chk("rst_busy_zero", busy, 0);
    chk("rst_sat_zero", sat, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mdl[i] = '0;
      last_v[i] = '0;
      q[i].delete();
    end
    chk("ready_before_edge", wready, 0);
    @(negedge clk);
    chk("ready_after_release", wready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2, t3, n, k, first_block, recovered;
    logic [31:0] bp [6];
    logic [1:0] bch;

    tbl[0] = '{32'h0000_0000, 2'd3, 1'b0, 0};
    tbl[1] = '{32'h0000_0000, 2'd3, 1'b1, 32};
    tbl[2] = '{32'h1234_5678, 2'd0, 1'b0, 13};
    tbl[3] = '{32'h1234_5678, 2'd0, 1'b1, 19};
    tbl[4] = '{32'h8000_0001, 2'd1, 1'b0, 2};
    tbl[5] = '{32'hFFFF_FFFF, 2'd2, 1'b1, 0};
    tbl[6] = '{32'hF0F0_F0F0, 2'd2, 1'b0, 16};
    tbl[7] = '{32'h0000_FF00, 2'd1, 1'b1, 24};
    tbl[8] = '{32'hDEAD_BEEF, 2'd3, 1'b0, 24};

    rst = 1'b1;
    wdata = '0; wch = '0; wmode = 1'b0; wvalid = 1'b0; crst = '0;
    s_wdata = '0; s_wch = '0; s_wmode = 1'b0; s_wvalid = 1'b0; s_crst = '0;
    @(negedge clk);
    do_reset();

    repeat (3) @(negedge clk);
    chk("idle_flat", flat, 0);
    chk("idle_busy", busy, 0);
    chk("idle_sat", sat, 0);
    chk("idle_ready", wready, 1);

    put(32'hFFFF_0000, 2'd1, 1'b0, t);
    expect_acc(1, 16);
    wait_to(t + 1);
    chk("single_busy_t1", busy, 4'b0010);
    wait_to(t + 5);
    chk("single_acc_t5", acc_of(1), 0);
    chk("single_busy_t5", busy[1], 1);
    wait_to(t + 6);
    chk("single_acc_t6", acc_of(1), 16);
    chk("single_busy_t6", busy, 0);
    chk("single_others", {acc_of(0), acc_of(2), acc_of(3)}, 0);

    put(32'h0000_000F, 2'd0, 1'b1, t);
    expect_acc(0, mdl[0] + 28);
    put(32'hAAAA_AAAA, 2'd2, 1'b0, t);
    expect_acc(2, mdl[2] + 16);
    put(32'h0000_0001, 2'd0, 1'b0, t);
    expect_acc(0, mdl[0] + 1);
    drain();
    chk("mixed_acc0", acc_of(0), 29);
    chk("mixed_acc2", acc_of(2), 16);

    for (int v = 0; v < 9; v++) begin
      put(tbl[v].data, tbl[v].ch, tbl[v].mode, t);
      expect_acc(int'(tbl[v].ch), mdl[tbl[v].ch] + 32'(tbl[v].exp));
    end
    drain();
    for (int c = 0; c < 4; c++)
      chk($sformatf("table_final_ch%0d", c), acc_of(c), mdl[c]);

    do_reset();
    bp[0] = 32'h1; bp[1] = 32'h3; bp[2] = 32'h7;
    bp[3] = 32'hF; bp[4] = 32'h1F; bp[5] = 32'h3F;
    put(32'h3, 2'd0, 1'b0, t);
    expect_acc(0, 2);
    n = 0; k = 0; first_block = -1; recovered = 0;
    wvalid = 1'b1;
    while (n < 6 && k < 200) begin
      bch = (n % 2 == 0) ? 2'd1 : 2'd2;
      wdata = bp[n]; wch = bch; wmode = 1'b0;
      if (wready) begin
        if (first_block >= 0) recovered = 1;
        expect_acc(int'(bch), mdl[bch] + $countones(bp[n]));
        n++;
      end else if (first_block < 0) begin
        first_block = n;
      end
      @(negedge clk);
      k++;
    end
    wvalid = 1'b0;
    chk("bp_accepted_before_full", first_block, 4);
    chk("bp_recovered", recovered, 1);
    chk("bp_all_accepted", n, 6);
    drain();
    chk("bp_acc1", acc_of(1), 1 + 3 + 5);
    chk("bp_acc2", acc_of(2), 2 + 4 + 6);

    do_reset();
    put(32'h0000_00FF, 2'd1, 1'b0, t);
    expect_acc(1, 8);
    drain();
    chk("clr_pre_acc", acc_of(1), 8);
    put(32'h0F0F_0F0F, 2'd1, 1'b0, t2);
    put(32'h0000_00FF, 2'd1, 1'b0, t3);
    wait_to(t2 + 5);
    crst = 4'b0010;
    expect_acc(1, 0);
    @(negedge clk);
    crst = 4'b0000;
    chk("clr_acc_zero", acc_of(1), 0);
    chk("clr_busy_kept", busy[1], 1);
    expect_acc(1, 8);
    drain();
    chk("clr_next_word", acc_of(1), 8);

    s_wdata = 32'hFFFF_FFFF; s_wch = 2'd3; s_wmode = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n = 0; k = 0;
      s_wvalid = 1'b1;
      while (n < ((r == 0) ? 1 : 3) && k < 100) begin
        if (s_wready) n++;
        @(negedge clk);
        k++;
      end
      s_wvalid = 1'b0;
      k = 0;
      while (s_busy !== 4'd0 && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (r == 0) begin
        chk("sat_first_acc", s_flat[18 +: 6], 32);
        chk("sat_first_flag", s_sat, 0);
      end else begin
        chk("sat_acc_max", s_flat[18 +: 6], 63);
        chk("sat_flag", s_sat, 4'b1000);
        chk("sat_others", s_flat[17:0], 0);
      end
    end
    s_crst = 4'b1000;
    @(negedge clk);
    s_crst = 4'b0000;
    chk("sat_clr_acc", s_flat[18 +: 6], 0);
    chk("sat_clr_flag", s_sat, 0);

    put(32'hFFFF_FFFF, 2'd0, 1'b0, t);
    put(32'hFFFF_FFFF, 2'd2, 1'b0, t);
    do_reset();
    repeat (12) @(negedge clk);
    chk("midrst_flat", flat, 0);
    chk("midrst_busy", busy, 0);

    for (int c = 0; c < 4; c++)
      chk($sformatf("sb_left_ch%0d", c), q[c].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
